// File: rtl/mux_scan_ctrl_if.sv
// Bus between the mux scan sequencer, its controller and the 8:1 mux it drives.
// The cont input exists only when MUX_SCAN_AUTORESTART_EN is defined.
interface mux_scan_ctrl_if #(
  parameter int NCH  = 8,
  parameter int SELW = 3,
  parameter int DWW  = 4
);
  logic            start;
  logic [NCH-1:0]  mask;
  logic [DWW-1:0]  dwell;
  logic            y_in;
`ifdef MUX_SCAN_AUTORESTART_EN
  logic            cont;
`endif
  logic [SELW-1:0] sel;
  logic            busy;
  logic            done;
  logic [NCH-1:0]  result;
  logic            result_valid;

`ifdef MUX_SCAN_AUTORESTART_EN
  modport master (
    output start, mask, dwell, y_in, cont,
    input  sel, busy, done, result, result_valid
  );

  modport slave (
    input  start, mask, dwell, y_in, cont,
    output sel, busy, done, result, result_valid
  );
`else
  modport master (
    output start, mask, dwell, y_in,
    input  sel, busy, done, result, result_valid
  );

  modport slave (
    input  start, mask, dwell, y_in,
    output sel, busy, done, result, result_valid
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the 8:1 mux select through masked channels, settles, samples y_in into a result word.
// Optional MUX_SCAN_AUTORESTART_EN adds cont: back-to-back passes without returning to IDLE.
module mux_scan_ctrl #(
  parameter int NCH  = 8,
  parameter int SELW = 3,
  parameter int DWW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [DWW-1:0]  cnt_q, cnt_d;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic [NCH-1:0]  mk_q, mk_d;
  logic [NCH-1:0]  result_q, result_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            zpend_q, zpend_d;
  logic [NCH-1:0]  upper;

  function automatic logic [SELW-1:0] lowest_set(input logic [NCH-1:0] m);
    logic [SELW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = SELW'(i);
    end
    return idx;
  endfunction

  function automatic logic [NCH-1:0] upper_bits(input logic [NCH-1:0] m,
                                                input logic [SELW-1:0] s);
    logic [NCH-1:0] up;
    up = '0;
    for (int i = 0; i < NCH; i++) begin
      up[i] = m[i] && (i > int'(s));
    end
    return up;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mk_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      zpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mk_q     <= mk_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      zpend_q  <= zpend_d;
    end
  end

  // An empty mask is accepted but finishes one edge later via zpend, so done
  // lands on the same relative edge a one-channel scan would use; busy never rises.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mk_d     = mk_q;
    result_d = result_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    zpend_d  = 1'b0;
    upper    = upper_bits(mk_q, sel_q);

    case (state_q)
      IDLE: begin
        if (zpend_q) begin
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else if (bus.start) begin
          mk_d     = bus.mask;
          dwell_d  = bus.dwell;
          cnt_d    = bus.dwell;
          result_d = '0;
          valid_d  = 1'b0;
          if (bus.mask != '0) begin
            sel_d   = lowest_set(bus.mask);
            state_d = SETTLE;
          end else begin
            zpend_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWW'(1);
        end else begin
          result_d[sel_q] = bus.y_in;
          if (upper != '0) begin
            sel_d = lowest_set(upper);
            cnt_d = dwell_q;
          end else begin
            done_d  = 1'b1;
            valid_d = 1'b1;
            state_d = IDLE;
`ifdef MUX_SCAN_AUTORESTART_EN
            // Result is not cleared on restart: each pass overwrites its bits in place.
            if (bus.cont) begin
              mk_d    = bus.mask;
              dwell_d = bus.dwell;
              cnt_d   = bus.dwell;
              if (bus.mask != '0) begin
                sel_d   = lowest_set(bus.mask);
                state_d = SETTLE;
              end
            end
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.sel          = sel_q;
  assign bus.busy         = (state_q == SETTLE);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: directed scans push expected results, a monitor checks each done.
// Autorestart pass sequence is exercised when MUX_SCAN_AUTORESTART_EN is defined.
module tb_mux_scan_ctrl;
  localparam int NCH  = 8;
  localparam int SELW = 3;
  localparam int DWW  = 4;

  typedef struct {
    logic [NCH-1:0] result;
    int             cycle;
    logic           busy;
    string          name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] pattern;
  exp_t exp_q[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mux_scan_ctrl_if #(.NCH(NCH), .SELW(SELW), .DWW(DWW)) bus ();

  mux_scan_ctrl #(.NCH(NCH), .SELW(SELW), .DWW(DWW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Mux model: the sampled bit is the pattern bit the DUT currently selects.
  assign bus.y_in = pattern[bus.sel];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_result"}, bus.result, e.result);
        checkOutput({e.name, "_valid"}, bus.result_valid, 1);
        checkOutput({e.name, "_done_cycle"}, cyc, e.cycle);
        checkOutput({e.name, "_busy_at_done"}, bus.busy, e.busy);
      end
    end
  end

  task automatic waitDrain(input string name);
    for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    checkOutput({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic applyStimulus(input string name, input logic [NCH-1:0] m,
                               input logic [DWW-1:0] d, input logic [NCH-1:0] pat,
                               input logic [NCH-1:0] exp_result, input int latency);
    int accept;
    @(negedge clk);
    pattern   = pat;
    bus.mask  = m;
    bus.dwell = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    accept    = cyc;
    exp_q.push_back('{result: exp_result, cycle: accept + latency, busy: 1'b0, name: name});
    bus.mask  = ~m;
    bus.dwell = '1;
    if (m == '0) begin
      @(negedge clk);
      checkOutput({name, "_busy_idle"}, bus.busy, 0);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (m[ch]) begin
        for (int t = 0; t <= int'(d); t++) begin
          @(negedge clk);
          checkOutput({name, "_sel"}, bus.sel, ch);
          if (t == 0) checkOutput({name, "_busy"}, bus.busy, 1);
        end
      end
    end
    waitDrain(name);
    checkOutput({name, "_busy_after"}, bus.busy, 0);
    repeat (2) @(negedge clk);
    checkOutput({name, "_result_hold"}, bus.result, exp_result);
    checkOutput({name, "_valid_hold"}, bus.result_valid, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accept;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mask  = '0;
    bus.dwell = '0;
    pattern   = '0;
`ifdef MUX_SCAN_AUTORESTART_EN
    bus.cont  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_sel", bus.sel, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_result", bus.result, 0);
    checkOutput("reset_valid", bus.result_valid, 0);
    rst = 1'b0;

    applyStimulus("full", 8'hFF, 4'd0, 8'hA5, 8'hA5, 8);
    applyStimulus("sparse", 8'h81, 4'd3, 8'hFF, 8'h81, 8);
    applyStimulus("zero_mask", 8'h00, 4'd0, 8'hFF, 8'h00, 1);
    applyStimulus("mixed", 8'h5A, 4'd1, 8'hF0, 8'h50, 8);

    // Start held high: ignored while busy and on the return edge, taken one edge later.
    @(negedge clk);
    pattern   = 8'h02;
    bus.mask  = 8'h02;
    bus.dwell = 4'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    accept = cyc;
    exp_q.push_back('{result: 8'h02, cycle: accept + 2, busy: 1'b0, name: "held_start_a"});
    exp_q.push_back('{result: 8'h02, cycle: accept + 5, busy: 1'b0, name: "held_start_b"});
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDrain("held_start");

    // Abort: busy start ignored, then reset mid-scan; no done may appear.
    @(negedge clk);
    pattern   = 8'hFF;
    bus.mask  = 8'hFF;
    bus.dwell = 4'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("abort_sel_mid", bus.sel, 1);
    checkOutput("abort_busy_mid", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_sel", bus.sel, 0);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_result", bus.result, 0);
    checkOutput("abort_valid", bus.result_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_stays_idle", bus.busy, 0);
    applyStimulus("after_abort", 8'hFF, 4'd0, 8'h3C, 8'h3C, 8);

`ifdef MUX_SCAN_AUTORESTART_EN
    // Continuous passes over channels 0..1; cont dropped during the last pass.
    @(negedge clk);
    pattern   = 8'h01;
    bus.mask  = 8'h03;
    bus.dwell = 4'd0;
    bus.cont  = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    accept    = cyc;
    for (int p = 0; p < 4; p++) begin
      pattern  = (p % 2 == 0) ? 8'h01 : 8'h02;
      bus.cont = (p < 3);
      exp_q.push_back('{result: (p % 2 == 0) ? 8'h01 : 8'h02, cycle: accept + 2 * p + 2,
                        busy: (p < 3), name: "autorestart"});
      @(negedge clk);
      checkOutput("autorestart_busy", bus.busy, 1);
      if (p > 0) checkOutput("autorestart_valid", bus.result_valid, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
    end
    waitDrain("autorestart");
    checkOutput("autorestart_busy_end", bus.busy, 0);
    bus.cont = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 8:1 bit multiplexer and drives its select lines.
- Steps the select through the channels enabled by a mask and holds each select for a programmable settle time.
- Samples the multiplexer's single-bit output for each enabled channel and assembles the samples into an 8-bit result word.
- Start/busy/done handshake toward the control logic.

Parameters:
- NCH, 8, number of multiplexer channels; fixed at 8 for this block.
- SELW, 3, select width; must equal log2(NCH).
- DWW, 4, width of the dwell (settle) count input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a scan; sampled only in IDLE.
- mask  input  NCH  channel enable bits; bit n enables channel n; latched on an accepted start.
- dwell  input  DWW  extra settle cycles per channel; latched on an accepted start.
- y_in  input  1  multiplexer output being sampled.
- sel  output  SELW  select lines driven to the multiplexer.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when a scan completes.
- result  output  NCH  sampled value per channel; masked-off channels read 0.
- result_valid  output  1  result holds a completed scan.

Behaviour:
- Reset values (rst high at a clk edge): sel=0, busy=0, done=0, result=0, result_valid=0, state IDLE. All internal registers are cleared.
- Reset mid-scan aborts the scan immediately. No done pulse is generated and the partial result is discarded (result=0).
- States: IDLE and SETTLE.
- IDLE:
  - start=1 at edge k accepts a scan: latch mask to mk and dwell to cnt, clear result to 0, set result_valid=0.
  - If mk is nonzero: sel is set to the lowest set bit of mk, busy=1, next state SETTLE.
  - If mk=0: done=1 and result_valid=1 at edge k+1, result stays 0, busy stays 0, sel is unchanged.
- SETTLE, evaluated at each edge:
  - If cnt!=0: cnt decrements.
  - If cnt=0: result[sel] takes y_in (the value present during the preceding cycle). Then:
    - If mk has a set bit above sel: sel advances to the next set bit, cnt reloads the latched dwell, state stays SETTLE.
    - Otherwise: busy=0, done=1, result_valid=1, next state IDLE.
- Timing: each enabled channel holds sel for exactly dwell+1 cycles. With N enabled channels and start accepted at edge k, done is high during the cycle after edge k+N*(dwell+1), for exactly one cycle.
- dwell=0 is legal and gives one cycle per channel.
- sel changes only at accept or advance edges. It never glitches through disabled channels.
- mask and dwell changes during a scan have no effect.
- start while busy is ignored. start on the same edge that returns to IDLE is ignored; start is honoured from the next edge.
- result and result_valid hold until the next accepted start or reset.
- Channel 7 is the final channel. There is no wrap past 7 in single-scan mode.

Optional Feature:
- Macro: MUX_SCAN_AUTORESTART_EN.
- Defined: adds input port cont (1 bit), which is sampled at the final-sample edge.
  - If cont=1 at that edge, the block pulses done and sets result_valid=1 with the completed word, as in a normal finish.
  - busy stays 1, mask and dwell are re-latched from the inputs, and sel returns to the lowest set bit of the new mask. The next pass starts with no IDLE cycle.
  - The result register updates bit by bit during the next pass; result_valid stays 1.
  - A re-latched mask of 0 ends the scan: busy=0, state IDLE.
  - cont=0 at the final edge finishes normally.
- Undefined: port cont is absent and behaviour is single-scan only.

Test Plan:
- Reset then idle: rst high for 2 cycles -> sel=0, busy=0, done=0, result=0x00, result_valid=0.
- Full scan: mask=0xFF, dwell=0, y_in driven as i[sel] with i=0xA5, one start pulse -> sel steps 0..7 one per cycle, done pulses 8 cycles after accept, result=0xA5, busy low with done.
- Sparse mask with dwell: mask=0x81, dwell=3, i=0xFF -> sel=0 for 4 cycles, then sel=7 for 4 cycles, done 8 cycles after accept, result=0x81.
- Zero mask: mask=0x00, start -> busy never rises, done pulses the next cycle, result=0x00, result_valid=1.
- Abort and busy-start: mask=0xFF, dwell=2; assert start again at cycle 3 (ignored), then rst at cycle 5 -> no done pulse, all outputs return to reset values; a fresh start then completes normally.
- With MUX_SCAN_AUTORESTART_EN: cont=1, mask=0x03, dwell=0, i toggles between 0x01 and 0x02 each pass -> done every 2 cycles, busy continuously 1, result alternates 0x01/0x02; drop cont -> busy falls after the current pass completes.
